alu_req_scheduler: RTL and testbench

//  Round-robin scheduler that shares the single registered 4-bit ALU between two requesters.
//  - Accepts one operation at a time through a valid/ready handshake.
//  - Drives the ALU operand and opcode inputs, waits out the ALU latency, then captures the result.
//  - Returns the result with the requester ID on a valid/ready response channel.
//  - Sits between the ui_in/uio_in decode logic and the ALU inside tt_um_andrewdamasta.

---
 rtl/alu_req_scheduler.sv | 201 ++++++++++++++++++++
 tb/tb_alu_req_scheduler.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_scheduler.sv
// ---------------------------------------------------------------------------
// alu_req_scheduler
//
// Purpose:
//   Round-robin scheduler that shares one registered ALU between two
//   requesters. One operation is accepted at a time through a valid/ready
//   handshake. The operands and opcode are registered onto the ALU inputs,
//   the ALU latency is waited out, and the result is captured. The result is
//   then returned with the owning requester ID on a valid/ready response
//   channel.
//
// Ports:
//   clk, rst_n               clock (rising edge), asynchronous active-low reset
//   req{0,1}_valid/_ready    request handshake, ready is combinational in IDLE
//   req{0,1}_a/_b/_op        request operands and opcode
//   alu_a/_b/_op             registered operands/opcode driven to the ALU
//   alu_result               ALU result, valid ALU_LAT cycles after operands
//   rsp_valid/_ready         response handshake
//   rsp_data/_id/_err        captured result, owner ID, divide-by-zero flag
//   busy                     scheduler is not idle
//
// Configuration:
//   DIV0_CHECK_EN  when defined, a divide by zero does not wait for the ALU.
//                  It is answered one cycle after accept with an all-ones
//                  result and rsp_err=1. When undefined, rsp_err is tied low
//                  and divides are issued like any other op.
// ---------------------------------------------------------------------------
module alu_req_scheduler #(
  parameter int ALU_LAT = 1,
  parameter int DW      = 4,
  parameter int OPW     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DW-1:0]     req0_a,
  input  logic [DW-1:0]     req0_b,
  input  logic [OPW-1:0]    req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DW-1:0]     req1_a,
  input  logic [DW-1:0]     req1_b,
  input  logic [OPW-1:0]    req1_op,
  output logic [DW-1:0]     alu_a,
  output logic [DW-1:0]     alu_b,
  output logic [OPW-1:0]    alu_op,
  input  logic [2*DW-1:0]   alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [2*DW-1:0]   rsp_data,
  output logic              rsp_id,
  output logic              rsp_err,
  output logic              busy
);

  // Counter wide enough for ALU_LAT-1 with ALU_LAT up to 7.
  localparam int CW = 3;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPT,
    RESP
  } state_e;

  state_e              state_q;
  logic [CW-1:0]       cnt_q;
  logic                id_q;
  logic                rr_last_q;
  logic [DW-1:0]       alu_a_q;
  logic [DW-1:0]       alu_b_q;
  logic [OPW-1:0]      alu_op_q;
  logic                rsp_valid_q;
  logic [2*DW-1:0]     rsp_data_q;
  logic                rsp_id_q;

  logic                grant0;
  logic                grant1;
  logic                accept;
  logic                sel_id;
  logic [DW-1:0]       sel_a;
  logic [DW-1:0]       sel_b;
  logic [OPW-1:0]      sel_op;

  // Arbitration: a lone requester wins; on contention the requester that
  // was not served last wins. rr_last_q resets to 1 so requester 0 goes first.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      grant0 = rr_last_q;
      grant1 = ~rr_last_q;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  assign req0_ready = (state_q == IDLE) & grant0;
  assign req1_ready = (state_q == IDLE) & grant1;
  assign accept     = req0_ready | req1_ready;

  // Payload of whichever requester is being accepted this cycle.
  assign sel_id = req1_ready;
  assign sel_a  = sel_id ? req1_a  : req0_a;
  assign sel_b  = sel_id ? req1_b  : req0_b;
  assign sel_op = sel_id ? req1_op : req0_op;

`ifdef DIV0_CHECK_EN
  localparam logic [OPW-1:0] OP_DIV_AB = OPW'(4);
  localparam logic [OPW-1:0] OP_DIV_BA = OPW'(5);

  logic div0_q;
  logic rsp_err_q;
  logic sel_div0;

  // Divisor is b for a/b and a for b/a.
  assign sel_div0 = ((sel_op == OP_DIV_AB) && (sel_b == '0)) ||
                    ((sel_op == OP_DIV_BA) && (sel_a == '0));
  assign rsp_err  = rsp_err_q;
`else
  assign rsp_err  = 1'b0;
`endif

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != IDLE);

  // Single-process FSM. ALU inputs only change on accept, so they hold their
  // last values through IDLE. A divide by zero jumps straight to the capture
  // step, which substitutes the error result, so the response appears one
  // cycle after accept regardless of ALU_LAT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      id_q        <= 1'b0;
      rr_last_q   <= 1'b1;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= 1'b0;
`ifdef DIV0_CHECK_EN
      div0_q      <= 1'b0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            alu_a_q   <= sel_a;
            alu_b_q   <= sel_b;
            alu_op_q  <= sel_op;
            id_q      <= sel_id;
            rr_last_q <= sel_id;
            cnt_q     <= CW'(ALU_LAT - 1);
`ifdef DIV0_CHECK_EN
            div0_q    <= sel_div0;
            state_q   <= sel_div0 ? CAPT : ISSUE;
`else
            state_q   <= ISSUE;
`endif
          end
        end
        ISSUE: begin
          if (cnt_q == '0) begin
            state_q <= CAPT;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        CAPT: begin
`ifdef DIV0_CHECK_EN
          rsp_data_q <= div0_q ? {(2*DW){1'b1}} : alu_result;
          rsp_err_q  <= div0_q;
`else
          rsp_data_q <= alu_result;
`endif
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_scheduler.sv
// ---------------------------------------------------------------------------
// tb_alu_req_scheduler
//
// Purpose:
//   Self-checking bench for alu_req_scheduler. Instance "dut" uses
//   ALU_LAT=1 and is driven by directed and random requests. A transaction
//   level reference model predicts grants, response timing and response
//   contents. Instance "dutB" uses ALU_LAT=3 for one directed latency case.
//   Both instances get a behavioural pipelined ALU.
//
// Ports: none (top-level bench). Honours DIV0_CHECK_EN like the design.
// ---------------------------------------------------------------------------
module tb_alu_req_scheduler;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;
`ifdef DIV0_CHECK_EN
  localparam bit DIV0 = 1'b1;
`else
  localparam bit DIV0 = 1'b0;
`endif

  int compared   = 0;
  int mismatched = 0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A signals
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_op, req1_op;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_op;
  logic [7:0] alu_result;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [7:0] rsp_data;

  // Instance B signals
  logic       b_req0_valid, b_req0_ready, b_req1_valid, b_req1_ready;
  logic [3:0] b_req0_a, b_req0_b, b_req1_a, b_req1_b;
  logic [2:0] b_req0_op, b_req1_op;
  logic [3:0] b_alu_a, b_alu_b;
  logic [2:0] b_alu_op;
  logic [7:0] b_alu_result;
  logic       b_rsp_valid, b_rsp_ready, b_rsp_id, b_rsp_err, b_busy;
  logic [7:0] b_rsp_data;

  alu_req_scheduler #(.ALU_LAT(LAT_A), .DW(4), .OPW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_err(rsp_err), .busy(busy)
  );

  alu_req_scheduler #(.ALU_LAT(LAT_B), .DW(4), .OPW(3)) dutB (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(b_req0_valid), .req0_ready(b_req0_ready),
    .req0_a(b_req0_a), .req0_b(b_req0_b), .req0_op(b_req0_op),
    .req1_valid(b_req1_valid), .req1_ready(b_req1_ready),
    .req1_a(b_req1_a), .req1_b(b_req1_b), .req1_op(b_req1_op),
    .alu_a(b_alu_a), .alu_b(b_alu_b), .alu_op(b_alu_op), .alu_result(b_alu_result),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data),
    .rsp_id(b_rsp_id), .rsp_err(b_rsp_err), .busy(b_busy)
  );

  // Behavioural ALU function; divide by zero returns 0 from the ALU itself.
  function automatic logic [7:0] aluf(input logic [3:0] a, input logic [3:0] b,
                                      input logic [2:0] op);
    case (op)
      3'd0:    return 8'(a) + 8'(b);
      3'd1:    return 8'(a) - 8'(b);
      3'd2:    return 8'(b) - 8'(a);
      3'd3:    return 8'(a) * 8'(b);
      3'd4:    return (b == 4'd0) ? 8'h00 : 8'(a / b);
      3'd5:    return (a == 4'd0) ? 8'h00 : 8'(b / a);
      3'd6:    return {4'h0, a & b};
      default: return {4'h0, a | b};
    endcase
  endfunction

  // Registered ALU models, one stage per latency cycle.
  logic [7:0] aluPipeA;
  logic [7:0] aluPipeB [LAT_B];
  always @(posedge clk) begin
    aluPipeA    <= aluf(alu_a, alu_b, alu_op);
    aluPipeB[0] <= aluf(b_alu_a, b_alu_b, b_alu_op);
    for (int i = 1; i < LAT_B; i++) aluPipeB[i] <= aluPipeB[i-1];
  end
  assign alu_result   = aluPipeA;
  assign b_alu_result = aluPipeB[LAT_B-1];

  // Reference model state: 0 idle, 1 waiting for result, 2 response pending.
  int         mPhase;
  int         mWait;
  bit         mRr;
  bit         mId;
  bit         mErr;
  logic [7:0] mData;
  logic [3:0] mLastA, mLastB;
  logic [2:0] mLastOp;

  // Requester-side state: pending requests hold valid and payload.
  bit         pending [2];
  logic [3:0] pa [2];
  logic [3:0] pb [2];
  logic [2:0] pop [2];

  bit         logId [$];
  logic [7:0] logData [$];

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic driveInputs();
    req0_valid = pending[0]; req0_a = pa[0]; req0_b = pb[0]; req0_op = pop[0];
    req1_valid = pending[1]; req1_a = pa[1]; req1_b = pb[1]; req1_op = pop[1];
  endtask

  task automatic modelReset();
    mPhase  = 0;
    mWait   = 0;
    mRr     = 1'b1;
    mLastA  = 4'h0;
    mLastB  = 4'h0;
    mLastOp = 3'h0;
    mErr    = 1'b0;
  endtask

  task automatic setReq(input int i, input logic [3:0] a, input logic [3:0] b,
                        input logic [2:0] op);
    pending[i] = 1'b1; pa[i] = a; pb[i] = b; pop[i] = op;
  endtask

  // One clock cycle on instance A: drive, check readies, clock, update model,
  // then check every registered output against the model.
  task automatic applyStimulus(input bit randReq, input int readyPct, input bit refill);
    bit g0, g1, acc, gid, rdy, newResp, div0;
    for (int i = 0; i < 2; i++) begin
      if (!pending[i] && randReq && $urandom_range(0, 1) == 1)
        setReq(i, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               3'($urandom_range(0, 7)));
      if (!pending[i] && refill) pending[i] = 1'b1;
    end
    rsp_ready = ($urandom_range(0, 99) < readyPct);
    driveInputs();
    #1;
    g0 = (mPhase == 0) && pending[0] && (!pending[1] || mRr);
    g1 = (mPhase == 0) && pending[1] && (!pending[0] || !mRr);
    checkOutput("req0_ready", req0_ready, g0);
    checkOutput("req1_ready", req1_ready, g1);
    acc = g0 | g1;
    gid = g1;
    rdy = rsp_ready;
    @(posedge clk);
    #1;
    newResp = 1'b0;
    if (mPhase == 1) begin
      mWait--;
      if (mWait == 0) begin
        mPhase  = 2;
        newResp = 1'b1;
      end
    end else if (mPhase == 2) begin
      if (rdy) mPhase = 0;
    end else if (acc) begin
      pending[gid] = 1'b0;
      mRr     = gid;
      mId     = gid;
      mLastA  = pa[gid];
      mLastB  = pb[gid];
      mLastOp = pop[gid];
      div0    = DIV0 && (((pop[gid] == 3'd4) && (pb[gid] == 4'd0)) ||
                         ((pop[gid] == 3'd5) && (pa[gid] == 4'd0)));
      mData   = div0 ? 8'hFF : aluf(pa[gid], pb[gid], pop[gid]);
      mErr    = div0;
      mWait   = div0 ? 1 : LAT_A + 1;
      mPhase  = 1;
    end
    checkOutput("rsp_valid", rsp_valid, mPhase == 2);
    checkOutput("busy", busy, mPhase != 0);
    checkOutput("alu_a", alu_a, mLastA);
    checkOutput("alu_b", alu_b, mLastB);
    checkOutput("alu_op", alu_op, mLastOp);
    if (mPhase == 2) begin
      checkOutput("rsp_data", rsp_data, mData);
      checkOutput("rsp_id", rsp_id, mId);
      checkOutput("rsp_err", rsp_err, mErr);
    end
    if (newResp) begin
      logId.push_back(rsp_id);
      logData.push_back(rsp_data);
    end
  endtask

  task automatic runUntilIdle(input int readyPct);
    int n = 0;
    do begin
      applyStimulus(1'b0, readyPct, 1'b0);
      n++;
    end while ((mPhase != 0 || pending[0] || pending[1]) && n < 60);
    compared++;
    assert (n < 60) else begin
      mismatched++;
      $error("[TB] FAIL drain_timeout observed=%0d cycles required<60", n);
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    pending[0] = 1'b0;
    pending[1] = 1'b0;
    driveInputs();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_data", rsp_data, 0);
    checkOutput("rst_rsp_id", rsp_id, 0);
    checkOutput("rst_rsp_err", rsp_err, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_alu_a", alu_a, 0);
    checkOutput("rst_alu_b", alu_b, 0);
    checkOutput("rst_alu_op", alu_op, 0);
    rst_n = 1'b1;
    modelReset();
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      pending[i] = 1'b0; pa[i] = 4'h0; pb[i] = 4'h0; pop[i] = 3'h0;
    end
    driveInputs();
    b_req0_valid = 1'b0; b_req0_a = 4'h0; b_req0_b = 4'h0; b_req0_op = 3'h0;
    b_req1_valid = 1'b0; b_req1_a = 4'h0; b_req1_b = 4'h0; b_req1_op = 3'h0;
    b_rsp_ready  = 1'b1;
    modelReset();
    $display("[TB] start");
    doReset();

    // Single add from requester 0.
    logId.delete(); logData.delete();
    setReq(0, 4'd3, 4'd5, 3'd0);
    runUntilIdle(100);
    checkOutput("s1_count", logData.size(), 1);
    if (logData.size() > 0) begin
      checkOutput("s1_data", logData[0], 8'h08);
      checkOutput("s1_id", logId[0], 0);
    end

    // Both requesters held valid: strict alternation from reset.
    doReset();
    logId.delete(); logData.delete();
    setReq(0, 4'd7, 4'd2, 3'd3);
    setReq(1, 4'd9, 4'd12, 3'd6);
    n = 0;
    while (logId.size() < 4 && n < 40) begin
      applyStimulus(1'b0, 100, 1'b1);
      n++;
    end
    checkOutput("s2_count", logId.size(), 4);
    for (int k = 0; k < 4 && k < logId.size(); k++) begin
      checkOutput("s2_order", logId[k], k % 2);
      checkOutput("s2_data", logData[k], (k % 2 == 0) ? 8'h0E : 8'h08);
    end
    runUntilIdle(100);

    // Response back-pressure: held stable, no readies while stalled.
    setReq(0, 4'd1, 4'd2, 3'd7);
    n = 0;
    while (mPhase != 2 && n < 10) begin
      applyStimulus(1'b0, 0, 1'b0);
      n++;
    end
    checkOutput("s3_reached_resp", mPhase, 2);
    setReq(1, 4'd4, 4'd4, 3'd0);
    repeat (5) applyStimulus(1'b0, 0, 1'b0);
    runUntilIdle(100);

    // Reset during ISSUE: no response; requester 0 wins afterwards.
    setReq(0, 4'd2, 4'd2, 3'd0);
    runUntilIdle(100);
    setReq(0, 4'd5, 4'd1, 3'd0);
    setReq(1, 4'd6, 4'd1, 3'd0);
    applyStimulus(1'b0, 100, 1'b0);
    checkOutput("s5_in_issue", busy, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("s5_async_busy", busy, 0);
    checkOutput("s5_async_valid", rsp_valid, 0);
    doReset();
    repeat (3) applyStimulus(1'b0, 100, 1'b0);
    logId.delete(); logData.delete();
    setReq(0, 4'd5, 4'd1, 3'd0);
    setReq(1, 4'd6, 4'd1, 3'd0);
    runUntilIdle(100);
    checkOutput("s5_count", logId.size(), 2);
    if (logId.size() > 0) checkOutput("s5_first_id", logId[0], 0);

    // Divide by zero.
    logId.delete(); logData.delete();
    setReq(0, 4'd6, 4'd0, 3'd4);
    runUntilIdle(100);
    checkOutput("s6_count", logData.size(), 1);
    if (logData.size() > 0) checkOutput("s6_data", logData[0], DIV0 ? 8'hFF : 8'h00);

    // Random traffic with random back-pressure.
    repeat (400) applyStimulus(1'b1, 70, 1'b0);
    runUntilIdle(100);

    // Latency 3 on instance B.
    b_req1_a = 4'd15; b_req1_b = 4'd4; b_req1_op = 3'd1; b_req1_valid = 1'b1;
    b_rsp_ready = 1'b1;
    #1;
    checkOutput("s4_req1_ready", b_req1_ready, 1);
    checkOutput("s4_req0_ready", b_req0_ready, 0);
    @(posedge clk);
    #1;
    b_req1_valid = 1'b0;
    checkOutput("s4_alu_a", b_alu_a, 15);
    checkOutput("s4_alu_b", b_alu_b, 4);
    n = 0;
    while (!b_rsp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("s4_latency", n, 4);
    checkOutput("s4_data", b_rsp_data, 8'h0B);
    checkOutput("s4_id", b_rsp_id, 1);
    checkOutput("s4_err", b_rsp_err, 0);
    @(posedge clk);
    #1;
    checkOutput("s4_valid_drop", b_rsp_valid, 0);
    checkOutput("s4_idle", b_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
